// File: rtl/decomp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decomp_stream_ctrl
//  Brief    : Block sequencer for the decompressor core. Primes and refills
//             the core from a valid/ready source, gates the core enable under
//             backpressure, and buffers decoded (or raw bypass) lines in a
//             small output FIFO for a valid/ready sink.
//  Revision : 1.0 - initial release
// ============================================================================
module decomp_stream_ctrl #(
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LINES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_comp_flag,
  input  logic [CNT_W-1:0]  i_num_lines,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_core_en,
  output logic              o_core_update,
  output logic              o_core_comp_flag,
  output logic [DATA_W-1:0] o_core_data,
  input  logic              i_core_refill,
  input  logic              i_core_line_vld,
  input  logic [DATA_W-1:0] i_core_line,
  output logic              o_dst_valid,
  input  logic              i_dst_ready,
  output logic [DATA_W-1:0] o_dst_data,
  output logic              o_dst_last
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(FIFO_DEPTH);
  localparam logic [1:0]         c_prime_last = 2'(PRIME_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_RUN    = 3'd2,
    S_BYPASS = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_comp;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_line_cnt;
  logic [1:0]         r_prime_cnt;
  logic               r_overflow;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic               r_last_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_fifo_cnt;

  logic               w_start_acc;
  logic               w_push_req;
  logic               w_push_last;
  logic [DATA_W-1:0]  w_push_data;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_space;
  logic               w_not_full;
  logic               w_line_is_last;

  // FIFO status; one slot is held back in RUN for a line already in flight in the core
  assign w_empty        = (r_fifo_cnt == '0);
  assign w_full         = (r_fifo_cnt == c_depth);
  assign w_not_full     = (r_fifo_cnt < c_depth);
  assign w_space        = ((r_fifo_cnt + c_cnt_w'(1)) < c_depth);
  assign w_line_is_last = (({1'b0, r_line_cnt} + (CNT_W+1)'(1)) == {1'b0, r_target});
  assign w_pop          = ~w_empty & i_dst_ready;
  assign w_push_ok      = w_push_req & ~w_full;

  assign o_busy           = (r_state != S_IDLE);
  assign o_overflow       = r_overflow;
  assign o_core_comp_flag = r_comp;
  assign o_core_data      = i_src_data;
  assign o_dst_valid      = ~w_empty;
  assign o_dst_data       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_dst_last       = ~w_empty & r_last_mem[r_rd_ptr];

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and per-state source/core/FIFO-push control
  always_comb begin
    w_state_nxt   = r_state;
    w_start_acc   = 1'b0;
    o_src_ready   = 1'b0;
    o_core_update = 1'b0;
    o_core_en     = 1'b0;
    o_done        = 1'b0;
    w_push_req    = 1'b0;
    w_push_last   = 1'b0;
    w_push_data   = i_core_line;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = i_comp_flag ? S_PRIME : S_BYPASS;
        end
      end
      S_PRIME: begin
        o_src_ready   = 1'b1;
        o_core_update = i_src_valid;
        if (i_src_valid && (r_prime_cnt == c_prime_last)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Hold the core while it waits on a refill the source cannot supply yet
        o_core_en     = w_space & ~(i_core_refill & ~i_src_valid);
        o_src_ready   = i_core_refill & o_core_en;
        o_core_update = i_core_refill & o_core_en;
        if (i_core_line_vld) begin
          w_push_req  = 1'b1;
          w_push_last = w_line_is_last;
          if (w_line_is_last) w_state_nxt = S_DRAIN;
        end
      end
      S_BYPASS: begin
        o_src_ready = w_not_full;
        w_push_data = i_src_data;
        if (i_src_valid && w_not_full) begin
          w_push_req  = 1'b1;
          w_push_last = w_line_is_last;
          if (w_line_is_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Block parameters, line/prime counters and the sticky overflow flag
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_comp      <= 1'b0;
      r_target    <= '0;
      r_line_cnt  <= '0;
      r_prime_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (w_start_acc) begin
      r_comp      <= i_comp_flag;
      r_target    <= (i_num_lines == '0) ? CNT_W'(1) : i_num_lines;
      r_line_cnt  <= '0;
      r_prime_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if ((r_state == S_PRIME) && i_src_valid) r_prime_cnt <= r_prime_cnt + 2'd1;
      // A dropped line still counts toward the block so the block can terminate
      if (w_push_req)          r_line_cnt <= r_line_cnt + CNT_W'(1);
      if (w_push_req && w_full) r_overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_push_ok && !w_pop)      r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
      else if (!w_push_ok && w_pop) r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
    end
  end

  // FIFO storage; contents are only observed through a valid pointer range
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr]      <= w_push_data;
      r_last_mem[r_wr_ptr] <= w_push_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decomp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decomp_stream_ctrl
//  Brief    : Directed self-checking bench for decomp_stream_ctrl: bypass,
//             priming/refill, source starvation, sink backpressure, forced
//             overflow and asynchronous reset mid-block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decomp_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, comp, src_valid, core_refill, core_line_vld, dst_ready;
  logic [7:0]   num;
  logic [127:0] src_data, core_line;
  logic         busy, done, overflow, src_ready, core_en, core_update, core_comp_flag;
  logic         dst_valid, dst_last;
  logic [127:0] core_data, dst_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [127:0] A1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_00A1;
  localparam logic [127:0] A2 = 128'hA2;
  localparam logic [127:0] A3 = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_00A3;
  localparam logic [127:0] C1 = 128'hC1;
  localparam logic [127:0] C2 = 128'hC2;

  always #5 clk = ~clk;

  decomp_stream_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_comp_flag(comp),
    .i_num_lines(num), .o_busy(busy), .o_done(done), .o_overflow(overflow),
    .i_src_valid(src_valid), .o_src_ready(src_ready), .i_src_data(src_data),
    .o_core_en(core_en), .o_core_update(core_update),
    .o_core_comp_flag(core_comp_flag), .o_core_data(core_data),
    .i_core_refill(core_refill), .i_core_line_vld(core_line_vld),
    .i_core_line(core_line), .o_dst_valid(dst_valid), .i_dst_ready(dst_ready),
    .o_dst_data(dst_data), .o_dst_last(dst_last)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; comp = 1'b0; num = 8'd0; src_valid = 1'b0;
    src_data = '0; core_refill = 1'b0; core_line_vld = 1'b0; core_line = '0;
    dst_ready = 1'b0;
    #3 reset = 1'b0;
    #2;
    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_update", core_update, 1'b0);
    check("rst_comp_flag", core_comp_flag, 1'b0);
    check("rst_dst_valid", dst_valid, 1'b0);
    check("rst_dst_last", dst_last, 1'b0);
    check("rst_dst_data", dst_data, 128'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1. Bypass block of 3 lines
    start = 1'b1; comp = 1'b0; num = 8'd3; dst_ready = 1'b1;
    tick();
    start = 1'b0;
    check("byp_busy", busy, 1'b1);
    check("byp_src_ready", src_ready, 1'b1);
    check("byp_core_en", core_en, 1'b0);
    src_valid = 1'b1; src_data = A1;
    tick();
    check("byp_valid1", dst_valid, 1'b1);
    check("byp_data1", dst_data, A1);
    check("byp_last1", dst_last, 1'b0);
    src_data = A2;
    tick();
    check("byp_data2", dst_data, A2);
    check("byp_last2", dst_last, 1'b0);
    src_data = A3;
    tick();
    src_valid = 1'b0;
    check("byp_data3", dst_data, A3);
    check("byp_last3", dst_last, 1'b1);
    check("byp_drain_src_ready", src_ready, 1'b0);
    check("byp_done_early", done, 1'b0);
    tick();
    check("byp_empty", dst_valid, 1'b0);
    check("byp_done_not_yet", done, 1'b0);
    tick();
    check("byp_done", done, 1'b1);
    check("byp_busy_done", busy, 1'b1);
    tick();
    check("byp_done_pulse", done, 1'b0);
    check("byp_idle", busy, 1'b0);

    // 2. Compressed block of 4 lines: priming, then refill handshake
    start = 1'b1; comp = 1'b1; num = 8'd4;
    tick();
    start = 1'b0;
    check("cmp_flag", core_comp_flag, 1'b1);
    check("prime_src_ready", src_ready, 1'b1);
    check("prime_idle_update", core_update, 1'b0);
    src_valid = 1'b1; src_data = C1;
    #1;
    check("prime_update1", core_update, 1'b1);
    check("prime_core_data", core_data, C1);
    check("prime_en1", core_en, 1'b0);
    tick();
    src_data = C2;
    #1;
    check("prime_update2", core_update, 1'b1);
    check("prime_en2", core_en, 1'b0);
    tick();
    check("run_en", core_en, 1'b1);
    check("run_src_ready_norefill", src_ready, 1'b0);
    check("run_update_norefill", core_update, 1'b0);
    core_refill = 1'b1;
    #1;
    check("refill_src_ready", src_ready, 1'b1);
    check("refill_update", core_update, 1'b1);
    tick();

    // 3. Source starvation while the core asks for a refill
    src_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("starve_core_en", core_en, 1'b0);
      check("starve_update", core_update, 1'b0);
      tick();
    end
    src_valid = 1'b1;
    #1;
    check("unstarve_update", core_update, 1'b1);
    check("unstarve_en", core_en, 1'b1);
    tick();
    core_refill = 1'b0; src_valid = 1'b0;

    // 4. Sink backpressure: enable drops at DEPTH-1 entries, then ordered drain
    dst_ready = 1'b0;
    core_line_vld = 1'b1; core_line = 128'hD1;
    tick();
    check("bp_valid", dst_valid, 1'b1);
    check("bp_head_d1", dst_data, 128'hD1);
    check("bp_en_cnt1", core_en, 1'b1);
    core_line = 128'hD2;
    tick();
    check("bp_en_cnt2", core_en, 1'b1);
    core_line = 128'hD3;
    tick();
    core_line_vld = 1'b0;
    check("bp_en_cnt3", core_en, 1'b0);
    dst_ready = 1'b1;
    #1;
    check("bp_head_still_d1", dst_data, 128'hD1);
    tick();
    check("bp_head_d2", dst_data, 128'hD2);
    check("bp_en_reopen", core_en, 1'b1);
    core_line_vld = 1'b1; core_line = 128'hD4;
    tick();
    core_line_vld = 1'b0;
    check("bp_head_d3", dst_data, 128'hD3);
    check("bp_last_d3", dst_last, 1'b0);
    check("bp_drain_en", core_en, 1'b0);
    tick();
    check("bp_head_d4", dst_data, 128'hD4);
    check("bp_last_d4", dst_last, 1'b1);
    tick();
    check("bp_empty", dst_valid, 1'b0);
    tick();
    check("bp_done", done, 1'b1);
    check("bp_no_ovf", overflow, 1'b0);
    tick();

    // 5. Forced overflow: 5th line with the FIFO full is dropped
    start = 1'b1; comp = 1'b1; num = 8'd8;
    tick();
    start = 1'b0; src_valid = 1'b1;
    tick(); tick();
    src_valid = 1'b0; dst_ready = 1'b0; core_line_vld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      core_line = 128'hE0 + 128'(i);
      tick();
    end
    check("ovf_before", overflow, 1'b0);
    core_line = 128'hE5;
    tick();
    core_line_vld = 1'b0;
    check("ovf_set", overflow, 1'b1);
    check("ovf_head_e1", dst_data, 128'hE1);
    tick();
    check("ovf_sticky", overflow, 1'b1);
    dst_ready = 1'b1;
    tick(); tick();
    check("ovf_head_e3", dst_data, 128'hE3);
    core_line_vld = 1'b1;
    core_line = 128'hF6; tick();
    core_line = 128'hF7; tick();
    core_line = 128'hF8; tick();
    core_line_vld = 1'b0;
    check("ovf_head_f7", dst_data, 128'hF7);
    check("ovf_last_f7", dst_last, 1'b0);
    tick();
    check("ovf_head_f8", dst_data, 128'hF8);
    check("ovf_last_f8", dst_last, 1'b1);
    tick(); tick();
    check("ovf_done", done, 1'b1);
    tick();
    check("ovf_sticky_idle", overflow, 1'b1);
    // num_lines = 0 is treated as a single-line block; start clears overflow
    start = 1'b1; comp = 1'b0; num = 8'd0;
    tick();
    start = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    check("num0_comp_flag", core_comp_flag, 1'b0);
    src_valid = 1'b1; src_data = 128'h61;
    tick();
    src_valid = 1'b0;
    check("num0_data", dst_data, 128'h61);
    check("num0_last", dst_last, 1'b1);
    tick(); tick();
    check("num0_done", done, 1'b1);
    tick();

    // 6. Async reset in RUN with 2 lines queued, then a fresh block
    start = 1'b1; comp = 1'b1; num = 8'd5;
    tick();
    start = 1'b0; src_valid = 1'b1;
    tick(); tick();
    src_valid = 1'b0; dst_ready = 1'b0; core_line_vld = 1'b1;
    core_line = 128'h71; tick();
    core_line = 128'h72; tick();
    core_line_vld = 1'b0;
    check("rstmid_queued", dst_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("rstmid_dst_valid", dst_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_core_en", core_en, 1'b0);
    check("rstmid_src_ready", src_ready, 1'b0);
    check("rstmid_comp_flag", core_comp_flag, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1; comp = 1'b0; num = 8'd2;
    tick();
    start = 1'b0; dst_ready = 1'b1; src_valid = 1'b1; src_data = 128'h81;
    tick();
    check("post_head_h1", dst_data, 128'h81);
    src_data = 128'h82;
    tick();
    src_valid = 1'b0;
    check("post_head_h2", dst_data, 128'h82);
    check("post_last_h2", dst_last, 1'b1);
    tick(); tick();
    check("post_done", done, 1'b1);
    tick();
    check("post_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
